// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions
// and the fixed handler vector / PRId contents.
package exc_ctrl_pkg;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL     = 32'h0000_0000;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD_BIT = 31;

  // Return address for a faulting instruction: back up over the branch if in a delay slot.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] addr;
    addr = bd ? (pc - 32'd4) : pc;
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Combinational take decision: masked interrupts beat synchronous exceptions,
// and the winner selects the ExcCode.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       valid_m,
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exccode_m,
  output logic       exc_req,
  output logic [4:0] exc_code
);

  logic [5:0] pending;
  logic       int_req;
  logic       sync_exc;

  for (genvar gi = 0; gi < 6; gi++) begin : g_pend
    assign pending[gi] = im[gi] & hw_int[gi];
  end

  assign int_req  = valid_m & ie & ~exl & (|pending);
  assign sync_exc = valid_m & (exccode_m != EXC_INT);
  assign exc_req  = int_req | sync_exc;
  assign exc_code = int_req ? EXC_INT : exccode_m;

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception controller beside the M stage: owns SR/Cause/EPC/PRId,
// takes exceptions and erets, and serves mfc0/mtc0.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exccode_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic        eret_req,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc
);

  logic [5:0]  sr_im_reg;
  logic        sr_exl_reg;
  logic        sr_ie_reg;
  logic        cause_bd_reg;
  logic [5:0]  cause_ip_reg;
  logic [4:0]  cause_exc_reg;
  logic [31:0] epc_reg;
  logic [4:0]  exc_code;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  exc_prio u_prio (
    .valid_m  (valid_m),
    .ie       (sr_ie_reg),
    .exl      (sr_exl_reg),
    .im       (sr_im_reg),
    .hw_int   (hw_int),
    .exccode_m(exccode_m),
    .exc_req  (exc_req),
    .exc_code (exc_code)
  );

  assign eret_req    = valid_m & eret_m & ~exc_req;
  assign redirect_pc = exc_req ? HANDLER_ADDR : epc_reg;
  assign epc         = epc_reg;

  always_comb begin
    sr_word = 32'h0;
    sr_word[SR_IM_LO +: 6] = sr_im_reg;
    sr_word[SR_EXL_BIT]    = sr_exl_reg;
    sr_word[SR_IE_BIT]     = sr_ie_reg;
    cause_word = 32'h0;
    cause_word[CAUSE_BD_BIT]      = cause_bd_reg;
    cause_word[CAUSE_IP_LO +: 6]  = cause_ip_reg;
    cause_word[CAUSE_EXC_LO +: 5] = cause_exc_reg;
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = sr_word;
      CP0_CAUSE: cp0_rdata = cause_word;
      CP0_EPC:   cp0_rdata = epc_reg;
      CP0_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_reg     <= '0;
      sr_exl_reg    <= 1'b0;
      sr_ie_reg     <= 1'b0;
      cause_bd_reg  <= 1'b0;
      cause_ip_reg  <= '0;
      cause_exc_reg <= '0;
      epc_reg       <= '0;
    end else begin
      cause_ip_reg <= hw_int;
      if (exc_req) begin
        // Nested take keeps the original return point so the outer handler can still eret.
        cause_exc_reg <= exc_code;
        sr_exl_reg    <= 1'b1;
        if (!sr_exl_reg) begin
          epc_reg      <= exc_epc(pc_m, bd_m);
          cause_bd_reg <= bd_m;
        end
      end else begin
        if (cp0_we && cp0_addr == CP0_SR) begin
          sr_im_reg  <= cp0_wdata[SR_IM_LO +: 6];
          sr_exl_reg <= cp0_wdata[SR_EXL_BIT];
          sr_ie_reg  <= cp0_wdata[SR_IE_BIT];
        end
        if (cp0_we && cp0_addr == CP0_EPC) begin
          epc_reg <= cp0_wdata;
        end
        if (eret_req) begin
          sr_exl_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: hand-computed CP0 state and redirect values.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m;
  logic [31:0] pc_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic        eret_m;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] redirect_pc;
  logic [31:0] epc;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m),
    .exccode_m(exccode_m), .bd_m(bd_m), .eret_m(eret_m), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .hw_int(hw_int),
    .cp0_rdata(cp0_rdata), .exc_req(exc_req), .eret_req(eret_req),
    .redirect_pc(redirect_pc), .epc(epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    cp0_addr = addr;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    valid_m = 0; pc_m = 0; exccode_m = 0; bd_m = 0; eret_m = 0;
    cp0_we = 0; cp0_wdata = 0;
  endtask

  initial begin
    idle();
    cp0_addr = 0; hw_int = 0; reset = 1;
    step(); step();
    reset = 0;
    step();

    rd(5'd12, 32'h0, "reset_sr");
    rd(5'd13, 32'h0, "reset_cause");
    rd(5'd14, 32'h0, "reset_epc");
    hw_int = 6'h3f; valid_m = 1; #1;
    check("reset_no_int", {31'b0, exc_req}, 32'h0);
    hw_int = 6'h00;

    // RI, not in delay slot
    valid_m = 1; exccode_m = 5'd10; pc_m = 32'h3010; #1;
    check("ri_exc_req", {31'b0, exc_req}, 32'h1);
    check("ri_redirect", redirect_pc, 32'h4180);
    eret_m = 1; #1;
    check("eret_blocked_by_exc", {31'b0, eret_req}, 32'h0);
    eret_m = 0;
    step(); idle();
    check("ri_epc", epc, 32'h3010);
    rd(5'd13, 32'h0000_0028, "ri_cause");
    rd(5'd12, 32'h0000_0002, "ri_sr_exl");

    // eret back to 3010
    valid_m = 1; eret_m = 1; #1;
    check("eret1_req", {31'b0, eret_req}, 32'h1);
    check("eret1_redirect", redirect_pc, 32'h3010);
    step(); idle();
    rd(5'd12, 32'h0, "eret1_sr");

    // Ov in delay slot
    valid_m = 1; exccode_m = 5'd12; bd_m = 1; pc_m = 32'h3024;
    step(); idle();
    check("ov_epc", epc, 32'h3020);
    rd(5'd13, 32'h8000_0030, "ov_cause");

    // Nested AdEL with EXL=1 keeps EPC and BD
    valid_m = 1; exccode_m = 5'd4; pc_m = 32'h5000; #1;
    check("nest_exc_req", {31'b0, exc_req}, 32'h1);
    step(); idle();
    check("nest_epc_kept", epc, 32'h3020);
    rd(5'd13, 32'h8000_0010, "nest_cause");

    valid_m = 1; eret_m = 1; #1;
    check("eret2_redirect", redirect_pc, 32'h3020);
    step(); idle();

    // Enable IM[0] and IE
    valid_m = 1; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    step(); idle();
    rd(5'd12, 32'h0000_0401, "mtc0_sr");
    hw_int = 6'h01; #1;
    check("int_bubble", {31'b0, exc_req}, 32'h0);
    // Interrupt beats a simultaneous Ov
    valid_m = 1; exccode_m = 5'd12; pc_m = 32'h3010; #1;
    check("int_exc_req", {31'b0, exc_req}, 32'h1);
    check("int_redirect", redirect_pc, 32'h4180);
    step(); idle();
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr");
    check("int_epc", epc, 32'h3010);

    // EXL blocks the pending interrupt; eret then lets it in
    valid_m = 1; #1;
    check("exl_blocks_int", {31'b0, exc_req}, 32'h0);
    eret_m = 1; #1;
    check("eret3_req", {31'b0, eret_req}, 32'h1);
    check("eret3_redirect", redirect_pc, 32'h3010);
    step(); idle();
    rd(5'd12, 32'h0000_0401, "eret3_sr");
    valid_m = 1; pc_m = 32'h3050; #1;
    check("int_after_eret", {31'b0, exc_req}, 32'h1);
    step(); idle();
    check("int2_epc", epc, 32'h3050);
    hw_int = 6'h00;
    valid_m = 1; eret_m = 1;
    step(); idle();

    // mtc0 EPC collides with AdEL: write dropped
    valid_m = 1; exccode_m = 5'd4; pc_m = 32'h3060;
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'hdead_beef;
    step(); idle();
    check("collide_epc", epc, 32'h3060);
    valid_m = 1; cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    step(); idle();
    check("mtc0_epc", epc, 32'h0000_1234);
    valid_m = 1; cp0_we = 1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff;
    step(); idle();
    rd(5'd13, 32'h0000_0010, "cause_ro");
    rd(5'd15, 32'h0, "prid");
    rd(5'd3, 32'h0, "unmapped");

    // Reset wins over a take
    valid_m = 1; exccode_m = 5'd10; pc_m = 32'h3070; reset = 1; #1;
    check("pre_reset_exc", {31'b0, exc_req}, 32'h1);
    step(); idle(); reset = 0;
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    check("rst_epc", epc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Coprocessor-0 exception controller for the five-stage MIPS pipeline. It sits beside the M stage and collects the exception code and branch-delay flag that travel down the pipe from D. It combines them with six external hardware interrupt lines and decides each cycle whether to take an exception. On a take it flushes the pipe and redirects fetch to the handler. It also owns SR, Cause, EPC and PRId, serves mfc0/mtc0, and executes eret.

## Interface
- HANDLER_ADDR, 32'h0000_4180, exception vector
- PRID_VAL, 32'h0000_0000, read-only PRId contents
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- valid_m  in  1  M stage holds a real instruction (not a bubble)
- pc_m  in  32  PC of M-stage instruction
- exccode_m  in  5  pipelined exception code; 0 = none
- bd_m  in  1  M instruction is in a branch delay slot
- eret_m  in  1  M instruction is eret
- cp0_we  in  1  mtc0 in M
- cp0_addr  in  5  CP0 register number (mtc0/mfc0)
- cp0_wdata  in  32  mtc0 data
- hw_int  in  6  external interrupt lines, level-sensitive
- cp0_rdata  out  32  mfc0 data, combinational on cp0_addr
- exc_req  out  1  take exception this cycle; flush F/D/E/M
- eret_req  out  1  eret taken this cycle; flush and redirect
- redirect_pc  out  32  HANDLER_ADDR when exc_req, else EPC
- epc  out  32  current EPC register

## Operation
- Registers: SR(12) = IM[15:10], EXL[1], IE[0]; all other bits read 0. Cause(13) = BD[31], IP[15:10], ExcCode[6:2]; other bits 0. EPC(14) is 32 bits. PRId(15) = PRID_VAL. Reads of any other address return 0.
- Reset: SR = 0, Cause = 0, EPC = 0. All outputs follow from these state values.
- int_req = valid_m & IE & !EXL & |(IM & hw_int).
- sync_exc = valid_m & (exccode_m != 0).
- exc_req = int_req | sync_exc. If both are true, the interrupt wins and ExcCode is 0 (Int).
- Taken exception, captured at the clock edge:
  - Cause.ExcCode = chosen code.
  - If EXL was 0: EPC = (bd_m ? pc_m-4 : pc_m) & ~3, and Cause.BD = bd_m. If EXL was 1, EPC and BD are unchanged.
  - EXL = 1.
- eret_req = valid_m & eret_m & !exc_req. On the edge it clears EXL; redirect_pc = EPC.
- mtc0: writes SR/EPC masked fields when cp0_we & !exc_req. A write to Cause updates nothing, since it is read-only. A write to PRId is ignored.
- Cause.IP is registered from hw_int every cycle, independent of mask.
- Write/take collision in the same cycle: exception state wins and the mtc0 is dropped, because that instruction is being cancelled.

## Timing
- exc_req, eret_req and redirect_pc are combinational from M inputs plus registered state. Zero-cycle decision; register effects are visible the next cycle.
- mfc0 of a register written by mtc0 in the previous cycle returns the new value. There is no internal bypass within the same cycle, so E/M ordering guarantees correctness.
- Interrupt assertion: it is taken in the first cycle where valid_m=1 and the mask conditions hold. If it is deasserted before then, it is never taken.
- With EXL=1, interrupts are blocked. Synchronous exceptions are still taken, with EPC preserved.
- A reset that coincides with exc_req or eret_req has priority: all state returns to reset values.

## Structure
- Shared header head.v holds:
  - exccode constants: Int 0, AdEL 4, AdES 5, RI 10, Ov 12;
  - CP0 register numbers 12–15;
  - SR/Cause field bit positions.
- Natural sub-module: exc_prio, the combinational int/sync priority select and ExcCode mux. Registers stay in exc_ctrl.

## Test plan
- Reset, then mfc0 of 12/13/14 -> all read 0; exc_req=0 with hw_int=6'h3f.
- Send RI with exccode_m=10, pc_m=32'h3010, bd_m=0 -> exc_req=1, redirect_pc=32'h4180. Next cycle: EPC=32'h3010, ExcCode=10, EXL=1.
- Send Ov with bd_m=1, pc_m=32'h3024 -> EPC=32'h3020, Cause.BD=1.
- mtc0 SR=32'h0000_0401, then hw_int[0]=1 on a valid instruction -> exc_req, ExcCode=0. Repeat on a bubble (valid_m=0) -> no take.
- Set EXL=1 with a pending interrupt -> no take. eret with EPC=32'h3010 -> eret_req=1, redirect_pc=32'h3010, EXL=0. The interrupt is taken on the following valid cycle.
- mtc0 EPC while exccode_m=4 in the same cycle -> the write is dropped and EPC holds the exception PC. Reset asserted during exc_req -> SR/Cause/EPC are 0 next cycle.
